// File: rtl/line_option_packer.sv
// Producer end of the solver line FIFO: collects every candidate option of one row/column
// and writes them as a single 1024-bit word {line_index, option_count, options, zero pad}.
module line_option_packer #(
  parameter int SIZE      = 11,
  parameter int NUM_LINES = 2 * SIZE,
  parameter int IDX_W     = $clog2(2 * SIZE),
  parameter int CNT_W     = 7,
  parameter int MAX_OPT   = (1024 - IDX_W - CNT_W) / SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [IDX_W-1:0]  line_index,
  input  logic              opt_valid,
  output logic              opt_ready,
  input  logic [SIZE-1:0]   opt_data,
  input  logic              opt_last,
  input  logic              fifo_full,
  output logic              write_to_fifo,
  output logic [1023:0]     din,
  output logic              busy,
  output logic              overflow,
  output logic [IDX_W:0]    lines_written,
  output logic              all_done
);

  localparam int WORD_W  = 1024;
  localparam int PAY_W   = MAX_OPT * SIZE;
  localparam int PAY_MSB = WORD_W - IDX_W - CNT_W - 1;
  localparam logic [IDX_W:0] LINES_TARGET = (IDX_W + 1)'(NUM_LINES);
  localparam logic [CNT_W-1:0] SLOT_LIMIT = CNT_W'(MAX_OPT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_opt_ready;
  logic               w_accept;
  logic               w_do_write;
  logic               w_slot_free;
  logic               w_open_line;
  logic [IDX_W:0]     w_lines_inc;
  logic [WORD_W-1:0]  w_word;

  logic [IDX_W-1:0]   r_index;
  logic [CNT_W-1:0]   r_cnt;
  logic [PAY_W-1:0]   r_payload;
  logic               r_write;
  logic [WORD_W-1:0]  r_din;
  logic               r_overflow;
  logic [IDX_W:0]     r_lines;
  logic               r_all_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_opt_ready  = 1'b0;
    w_accept     = 1'b0;
    w_do_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (line_start) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        w_opt_ready = 1'b1;
        w_accept    = opt_valid;
        if (opt_valid && opt_last) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (!fifo_full) begin
          w_do_write   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_slot_free = (r_cnt < SLOT_LIMIT);
  assign w_open_line = (r_state == S_IDLE) && line_start;
  assign w_lines_inc = r_lines + 1'b1;

  always_comb begin
    w_word = '0;
    w_word[WORD_W-1 -: IDX_W]       = r_index;
    w_word[WORD_W-1-IDX_W -: CNT_W] = r_cnt;
    w_word[PAY_MSB -: PAY_W]        = r_payload;
  end

  // NOTE: the payload is deliberately not reset; it is cleared when a line opens and is
  // only copied to din at the end of that line, so its post-reset contents are never seen.
  always_ff @(posedge clk) begin
    if (w_open_line) begin
      r_payload <= '0;
    end else if (w_accept && w_slot_free) begin
      for (int k = 0; k < MAX_OPT; k++) begin
        if (r_cnt == CNT_W'(k)) r_payload[PAY_W-1-k*SIZE -: SIZE] <= opt_data;
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index    <= '0;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_din      <= '0;
      r_overflow <= 1'b0;
      r_lines    <= '0;
      r_all_done <= 1'b0;
    end else begin
      r_write <= w_do_write;
      if (w_open_line) begin
        r_index <= line_index;
        r_cnt   <= '0;
      end
      if (w_accept) begin
        if (w_slot_free) r_cnt      <= r_cnt + 1'b1;
        else             r_overflow <= 1'b1;
      end
      // The count saturates so a long run of extra lines cannot wrap it back under the target.
      if (w_do_write) begin
        r_din <= w_word;
        if (r_lines != '1) begin
          r_lines <= w_lines_inc;
          if (w_lines_inc == LINES_TARGET) r_all_done <= 1'b1;
        end
      end
    end
  end

  assign opt_ready     = w_opt_ready;
  assign write_to_fifo = r_write;
  assign din           = r_din;
  assign busy          = (r_state != S_IDLE);
  assign overflow      = r_overflow;
  assign lines_written = r_lines;
  assign all_done      = r_all_done;

endmodule

// File: tb/tb_line_option_packer.sv
// Directed bench for line_option_packer: word layout, FIFO back-pressure, overflow,
// mid-line reset, back-to-back lines and all_done.
module tb_line_option_packer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_start = 1'b0;
  logic [4:0]    line_index = '0;
  logic          opt_valid = 1'b0;
  logic          opt_ready;
  logic [10:0]   opt_data = '0;
  logic          opt_last = 1'b0;
  logic          fifo_full = 1'b0;
  logic          write_to_fifo;
  logic [1023:0] din;
  logic          busy;
  logic          overflow;
  logic [5:0]    lines_written;
  logic          all_done;

  int total = 0;
  int bad   = 0;

  line_option_packer dut (
    .clk           (clk),
    .rst           (rst),
    .line_start    (line_start),
    .line_index    (line_index),
    .opt_valid     (opt_valid),
    .opt_ready     (opt_ready),
    .opt_data      (opt_data),
    .opt_last      (opt_last),
    .fifo_full     (fifo_full),
    .write_to_fifo (write_to_fifo),
    .din           (din),
    .busy          (busy),
    .overflow      (overflow),
    .lines_written (lines_written),
    .all_done      (all_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [4:0] idx);
    line_start = 1'b1;
    line_index = idx;
    tick();
    line_start = 1'b0;
  endtask

  task automatic send_opt(input logic [10:0] d, input logic last);
    opt_valid = 1'b1;
    opt_data  = d;
    opt_last  = last;
    tick();
    opt_valid = 1'b0;
    opt_last  = 1'b0;
  endtask

  function automatic logic [1023:0] make_word(input int idx, input logic [10:0] opts[$]);
    logic [1023:0] w;
    logic [1023:0] slot;
    w = '0;
    w[1023 -: 5] = idx[4:0];
    w[1018 -: 7] = 7'(opts.size());
    foreach (opts[k]) begin
      slot = '0;
      slot[1011 -: 11] = opts[k];
      w = w | (slot >> (k * 11));
    end
    return w;
  endfunction

  initial begin
    logic [10:0]   q[$];
    logic [1023:0] exp_word;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_write", write_to_fifo, 0);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lines", lines_written, 0);
    check("rst_all_done", all_done, 0);
    check("rst_opt_ready", opt_ready, 0);
    rst = 1'b0;
    tick();

    // Line 3 with three options, FIFO free
    start_line(5'd3);
    check("a_busy_collect", busy, 1);
    check("a_ready_collect", opt_ready, 1);
    send_opt(11'h0F0, 1'b0);
    send_opt(11'h078, 1'b0);
    send_opt(11'h03C, 1'b1);
    check("a_no_early_strobe", write_to_fifo, 0);
    check("a_ready_write", opt_ready, 0);
    check("a_busy_write", busy, 1);
    tick();
    check("a_strobe", write_to_fifo, 1);
    check("a_index", din[1023:1019], 3);
    check("a_count", din[1018:1012], 3);
    check("a_slot0", din[1011:1001], 11'h0F0);
    check("a_slot1", din[1000:990], 11'h078);
    check("a_slot2", din[989:979], 11'h03C);
    check("a_pad", din[978:0], 0);
    check("a_lines", lines_written, 1);
    check("a_busy_idle", busy, 0);
    tick();
    check("a_strobe_one_cycle", write_to_fifo, 0);
    q = {11'h0F0, 11'h078, 11'h03C};
    check("a_din_held", din, make_word(3, q));

    // FIFO full for five cycles in WRITE
    fifo_full = 1'b1;
    start_line(5'd5);
    send_opt(11'h7FF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_no_strobe_full", write_to_fifo, 0);
      check("b_busy_full", busy, 1);
    end
    check("b_din_unchanged", din, make_word(3, q));
    fifo_full = 1'b0;
    tick();
    check("b_strobe_release", write_to_fifo, 1);
    q = {11'h7FF};
    check("b_word", din, make_word(5, q));
    tick();
    check("b_single_strobe", write_to_fifo, 0);
    check("b_lines", lines_written, 2);

    // Reset in COLLECT after two options
    start_line(5'd7);
    send_opt(11'h001, 1'b0);
    send_opt(11'h002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c_write", write_to_fifo, 0);
    check("c_din", din, 0);
    check("c_busy", busy, 0);
    check("c_lines", lines_written, 0);
    check("c_opt_ready", opt_ready, 0);
    tick();
    check("c_no_strobe", write_to_fifo, 0);
    start_line(5'd9);
    send_opt(11'h555, 1'b1);
    tick();
    check("c_strobe", write_to_fifo, 1);
    q = {11'h555};
    check("c_word_slot0", din, make_word(9, q));
    check("c_lines_after", lines_written, 1);

    // 93 options on line 0: the 93rd is dropped
    start_line(5'd0);
    q = {};
    for (int k = 1; k <= 92; k++) begin
      send_opt(11'(k), 1'b0);
      q.push_back(11'(k));
    end
    check("d_no_overflow_at_92", overflow, 0);
    send_opt(11'd93, 1'b1);
    check("d_overflow", overflow, 1);
    tick();
    check("d_strobe", write_to_fifo, 1);
    check("d_count", din[1018:1012], 92);
    check("d_slot91", din[1011-91*11 -: 11], 92);
    check("d_slot0", din[1011:1001], 1);
    check("d_word", din, make_word(0, q));
    check("d_lines", lines_written, 2);

    // Line 21 with one all-zero option
    start_line(5'd21);
    send_opt(11'h000, 1'b1);
    tick();
    check("e_strobe", write_to_fifo, 1);
    check("e_index", din[1023:1019], 21);
    check("e_count", din[1018:1012], 1);
    check("e_payload", din[1011:0], 0);
    check("e_overflow_sticky", overflow, 1);
    check("e_lines", lines_written, 3);

    // 22 lines back to back, each new line_start issued in the previous strobe cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f_overflow_cleared", overflow, 0);
    for (int i = 0; i < 22; i++) begin
      start_line(5'(i));
      send_opt(11'(i + 1), 1'b1);
      tick();
      check("f_strobe", write_to_fifo, 1);
      check("f_index", din[1023:1019], i);
      check("f_slot0", din[1011:1001], i + 1);
      check("f_all_done", all_done, (i == 21));
    end
    check("f_lines_22", lines_written, 22);
    start_line(5'd4);
    send_opt(11'h00F, 1'b1);
    tick();
    check("f_extra_strobe", write_to_fifo, 1);
    check("f_lines_23", lines_written, 23);
    check("f_all_done_sticky", all_done, 1);
    tick();
    check("f_idle", write_to_fifo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
